reg_alu_seq: RTL and testbench
==============================

# reg_alu_seq

Instruction sequencer for the 8×16 register-file/ALU datapath (`reg_alu`). It accepts one 16-bit micro-instruction at a time over a valid/ready handshake and drives the datapath control pins (`s`, `wr`, `operation`, read/write addresses, `d_in`) cycle by cycle. It supports immediate loads, register-to-register ALU operations, and a bounded repeat loop. It also keeps a sticky carry flag from the datapath `cout`.

## Interface
- No parameters. Widths are fixed by the datapath: 16-bit data, 3-bit register addresses, 2-bit ALU operation.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; returns the block to IDLE immediately.
- `instr_valid`  in  1  `instr`/`imm_in` are valid this cycle.
- `instr_ready`  out  1  block can accept an instruction (high only in IDLE).
- `instr`  in  16  fields:
  - [15:14] opcode: 00 NOP, 01 LOAD, 10 ALU, 11 REP.
  - [13:12] ALU op.
  - [11:9] write address (wa).
  - [8:6] read address a (ra).
  - [5:3] read address b (rb).
  - [2:0] n, the REP count (ignored for other opcodes).
- `imm_in`  in  16  immediate data for LOAD; captured at accept.
- `s`  out  1  datapath write-source select: 1 = external `d_in`, 0 = ALU result.
- `wr`  out  1  register-file write enable.
- `operation`  out  2  ALU op to datapath.
- `rd_addr_a`, `rd_addr_b`, `wr_addr`  out  3 each  datapath addresses.
- `d_in`  out  16  data to datapath (captured immediate).
- `cout`  in  1  ALU carry-out from datapath.
- `carry`  out  1  carry captured at the last ALU write-back.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse marking the final cycle of an instruction.

## Operation
- States: IDLE, NOPS, LOAD, EXEC, WB.
- Accept rule: an instruction is accepted on a rising edge where `instr_valid` and `instr_ready` are both high.
  - On accept, `instr` goes into a holding register and `imm_in` into the `d_in` register.
  - The loop counter loads `n` for REP and 0 for ALU.
- Transitions:
  - IDLE→NOPS on NOP; IDLE→LOAD on LOAD; IDLE→EXEC on ALU or REP.
  - NOPS→IDLE.
  - LOAD→IDLE.
  - EXEC→WB.
  - WB→EXEC if the counter is non-zero (counter decrements); WB→IDLE if the counter is 0.
- Per-state outputs (decoded from state and the holding register):
  - IDLE: `wr`=0, `instr_ready`=1.
  - NOPS: `wr`=0, `done`=1.
  - LOAD: `wr`=1, `s`=1, `wr_addr`=wa, `done`=1.
  - EXEC: `wr`=0, `s`=0, `rd_addr_a`=ra, `rd_addr_b`=rb, `operation`=op. This is the read/settle cycle.
  - WB: same addresses and op as EXEC, plus `wr`=1 and `wr_addr`=wa. `done`=1 only on the last iteration.
- Carry: `carry` is updated from `cout` on every WB edge. It is unchanged by LOAD and NOP.
- REP: runs n+1 EXEC/WB pairs. With wa=ra this accumulates into ra; each iteration reads the value written by the previous WB.
- `instr_valid` while busy is ignored; the instruction is not consumed.
- Reset values: state IDLE; `instr_ready`=1; `busy`=0; `done`=0; `wr`=0; `s`=0; `carry`=0; all addresses, `operation` and `d_in` = 0; counter 0.

## Timing
- Accept on edge E.
- NOP: NOPS during cycle E..E+1; `done` high there; `instr_ready` high again after E+1.
- LOAD: the write happens at edge E+1. Busy for 1 cycle.
- ALU: EXEC in cycle E..E+1, WB in cycle E+1..E+2, write at edge E+2. Busy for 2 cycles.
- REP n: busy for 2(n+1) cycles. Writes occur at edges E+2, E+4, …, E+2(n+1).
- Back-to-back: the next accept is possible on the edge right after the cycle where `done` is high (IDLE is 1 cycle minimum).
- `wr` is never high in EXEC, IDLE or NOPS, so no write can occur outside LOAD/WB.
- Reset asserted mid-instruction:
  - `wr` drops asynchronously, and the in-flight write is suppressed if reset is low at the edge.
  - The partially completed REP is abandoned.
  - The counter is cleared and `carry` is cleared.
- n=0 REP behaves exactly like ALU.

## Test plan
- Reset: assert `reset`=0 mid-REP → `wr`=0 immediately, `busy`=0, `carry`=0, `instr_ready`=1.
- LOAD: LOAD wa=3, `imm_in`=16'h1234 → `wr`=1 and `s`=1 for exactly one cycle; `d_out_a` with ra=3 reads 16'h1234 afterwards; `done` pulses once.
- ALU add: LOAD r1=16'h0005, LOAD r2=16'h0003, then ALU op=00 (add) wa=4 ra=1 rb=2 → r4=16'h0008; `busy` for 2 cycles; `carry`=0.
- Carry: LOAD r1=16'hFFFF, r2=16'h0001, ALU add wa=5 → r5=16'h0000, `carry`=1. A following LOAD leaves `carry`=1.
- REP: r1=5, r2=3, REP add wa=1 ra=1 rb=2 n=3 → r1=17 after 8 busy cycles; exactly 4 `wr` pulses; `done` only on the last.
- Handshake: hold `instr_valid`=1 with a new instruction during a busy ALU op → not accepted until `instr_ready`=1. NOP → one `done` pulse and no `wr`.

Source files
------------

// File: rtl/reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : reg_alu_seq
// Purpose  : Micro-instruction sequencer driving the 8x16 reg_alu datapath.
// Revision : 1.0 - initial release
// ============================================================================
module reg_alu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   input  logic [15:0] imm_in,
   output logic        s,
   output logic        wr,
   output logic [1:0]  operation,
   output logic [2:0]  rd_addr_a,
   output logic [2:0]  rd_addr_b,
   output logic [2:0]  wr_addr,
   output logic [15:0] d_in,
   input  logic        cout,
   output logic        carry,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] c_OP_NOP  = 2'b00;
   localparam logic [1:0] c_OP_LOAD = 2'b01;
   localparam logic [1:0] c_OP_REP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_NOPS = 3'd1,
      ST_LOAD = 3'd2,
      ST_EXEC = 3'd3,
      ST_WB   = 3'd4
   } state_t;

   state_t      r_state;
   logic [13:3] r_instr;
   logic [2:0]  r_cnt;

   logic [1:0]  w_opcode;
   logic [1:0]  w_op;
   logic [2:0]  w_wa;
   logic [2:0]  w_ra;
   logic [2:0]  w_rb;
   logic [2:0]  w_n;

   assign w_opcode = instr[15:14];
   assign w_op     = instr[13:12];
   assign w_wa     = instr[11:9];
   assign w_ra     = instr[8:6];
   assign w_rb     = instr[5:3];
   assign w_n      = instr[2:0];

   // All control pins are registered so the datapath sees glitch-free controls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_instr     <= '0;
         r_cnt       <= '0;
         instr_ready <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         wr          <= 1'b0;
         s           <= 1'b0;
         carry       <= 1'b0;
         operation   <= '0;
         rd_addr_a   <= '0;
         rd_addr_b   <= '0;
         wr_addr     <= '0;
         d_in        <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (instr_valid && instr_ready) begin
                  r_instr     <= instr[13:3];
                  d_in        <= imm_in;
                  r_cnt       <= (w_opcode == c_OP_REP) ? w_n : 3'd0;
                  instr_ready <= 1'b0;
                  busy        <= 1'b1;
                  case (w_opcode)
                     c_OP_NOP: begin
                        r_state <= ST_NOPS;
                        done    <= 1'b1;
                     end
                     c_OP_LOAD: begin
                        r_state <= ST_LOAD;
                        wr      <= 1'b1;
                        s       <= 1'b1;
                        wr_addr <= w_wa;
                        done    <= 1'b1;
                     end
                     default: begin
                        r_state   <= ST_EXEC;
                        s         <= 1'b0;
                        operation <= w_op;
                        rd_addr_a <= w_ra;
                        rd_addr_b <= w_rb;
                     end
                  endcase
               end
            end
            ST_NOPS, ST_LOAD: begin
               r_state     <= ST_IDLE;
               wr          <= 1'b0;
               s           <= 1'b0;
               done        <= 1'b0;
               busy        <= 1'b0;
               instr_ready <= 1'b1;
            end
            ST_EXEC: begin
               r_state <= ST_WB;
               wr      <= 1'b1;
               wr_addr <= r_instr[11:9];
               done    <= (r_cnt == 3'd0);
            end
            ST_WB: begin
               carry <= cout;
               wr    <= 1'b0;
               done  <= 1'b0;
               if (r_cnt != 3'd0) begin
                  // Next iteration re-reads the register just written back.
                  r_cnt     <= r_cnt - 3'd1;
                  r_state   <= ST_EXEC;
                  operation <= r_instr[13:12];
                  rd_addr_a <= r_instr[8:6];
                  rd_addr_b <= r_instr[5:3];
               end else begin
                  r_state     <= ST_IDLE;
                  busy        <= 1'b0;
                  instr_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               wr          <= 1'b0;
               s           <= 1'b0;
               done        <= 1'b0;
               busy        <= 1'b0;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_alu_seq
// Purpose  : Self-checking bench for reg_alu_seq with a behavioural datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_alu_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [15:0] imm_in = '0;
   logic        s;
   logic        wr;
   logic [1:0]  operation;
   logic [2:0]  rd_addr_a;
   logic [2:0]  rd_addr_b;
   logic [2:0]  wr_addr;
   logic [15:0] d_in;
   logic        cout;
   logic        carry;
   logic        busy;
   logic        done;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   reg_alu_seq dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .imm_in      (imm_in),
      .s           (s),
      .wr          (wr),
      .operation   (operation),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .wr_addr     (wr_addr),
      .d_in        (d_in),
      .cout        (cout),
      .carry       (carry),
      .busy        (busy),
      .done        (done)
   );

   // ALU semantics of the stand-in datapath: add, sub (cout = borrow), and, or.
   function automatic logic [16:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'b00:   return {1'b0, a} + {1'b0, b};
         2'b01:   return {1'b0, a} - {1'b0, b};
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   logic [15:0] regs [8] = '{default: 16'h0000};
   logic [16:0] stub_res;
   assign stub_res = alu_f(operation, regs[rd_addr_a], regs[rd_addr_b]);
   assign cout     = stub_res[16];

   always @(posedge clk) begin
      if (wr) regs[wr_addr] <= s ? d_in : stub_res[15:0];
   end

   // Reference model: architectural register contents and sticky carry.
   logic [15:0] mregs [8] = '{default: 16'h0000};
   logic        mcarry = 1'b0;

   function automatic logic [15:0] mk(input logic [1:0] opc, input logic [1:0] op, input logic [2:0] wa,
                                      input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] n);
      return {opc, op, wa, ra, rb, n};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_iter(input logic [15:0] ins, input int iters);
      logic [16:0] r;
      for (int k = 0; k < iters; k++) begin
         r = alu_f(ins[13:12], mregs[ins[8:6]], mregs[ins[5:3]]);
         mregs[ins[11:9]] = r[15:0];
         mcarry = r[16];
      end
   endtask

   task automatic wait_ready(input string tag);
      int to;
      to = 0;
      @(negedge clk);
      while (!instr_ready && to < 50) begin
         @(negedge clk);
         to++;
      end
      check({tag, "/ready"}, {31'd0, instr_ready}, 32'd1);
   endtask

   task automatic run(input logic [15:0] ins, input logic [15:0] imm, input string tag);
      int busy_c, wr_c, done_c, s_c, exp_busy, exp_wr, exp_s;
      logic last_done;
      logic [1:0] opc;
      opc = ins[15:14];
      wait_ready(tag);
      instr = ins;
      imm_in = imm;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      imm_in = 16'($urandom);
      busy_c = 0; wr_c = 0; done_c = 0; s_c = 0; last_done = 1'b0;
      while (busy && busy_c < 40) begin
         busy_c++;
         wr_c += int'(wr);
         done_c += int'(done);
         s_c += int'(s);
         last_done = done;
         @(posedge clk);
         #1;
      end
      case (opc)
         2'b00: begin exp_busy = 1; exp_wr = 0; exp_s = 0; end
         2'b01: begin exp_busy = 1; exp_wr = 1; exp_s = 1; mregs[ins[11:9]] = imm; end
         2'b10: begin exp_busy = 2; exp_wr = 1; exp_s = 0; model_iter(ins, 1); end
         default: begin
            exp_busy = 2 * (int'(ins[2:0]) + 1);
            exp_wr = int'(ins[2:0]) + 1;
            exp_s = 0;
            model_iter(ins, int'(ins[2:0]) + 1);
         end
      endcase
      check({tag, "/busy_cycles"}, busy_c, exp_busy);
      check({tag, "/wr_pulses"}, wr_c, exp_wr);
      check({tag, "/s_cycles"}, s_c, exp_s);
      check({tag, "/done_pulses"}, done_c, 1);
      check({tag, "/done_last"}, {31'd0, last_done}, 32'd1);
      check({tag, "/carry"}, {31'd0, carry}, {31'd0, mcarry});
      check({tag, "/reg_wa"}, {16'd0, regs[ins[11:9]]}, {16'd0, mregs[ins[11:9]]});
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ins;

      // Reset state
      #12;
      check("rst/ready_in_reset", {31'd0, instr_ready}, 32'd1);
      check("rst/wr_in_reset", {31'd0, wr}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst/busy", {31'd0, busy}, 32'd0);
      check("rst/done", {31'd0, done}, 32'd0);
      check("rst/s", {31'd0, s}, 32'd0);
      check("rst/carry", {31'd0, carry}, 32'd0);
      check("rst/ready", {31'd0, instr_ready}, 32'd1);
      check("rst/addr_op_din", {5'd0, operation, rd_addr_a, rd_addr_b, wr_addr, d_in},
            {5'd0, 2'd0, 3'd0, 3'd0, 3'd0, 16'd0});

      // LOAD
      run(mk(2'b01, 2'b00, 3'd3, 3'd0, 3'd0, 3'd0), 16'h1234, "load_r3");
      check("load_r3/value", {16'd0, regs[3]}, 32'h1234);

      // ALU add
      run(mk(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0), 16'h0005, "load_r1");
      run(mk(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'h0003, "load_r2");
      run(mk(2'b10, 2'b00, 3'd4, 3'd1, 3'd2, 3'd0), 16'h0000, "alu_add");
      check("alu_add/r4", {16'd0, regs[4]}, 32'h0008);
      check("alu_add/carry0", {31'd0, carry}, 32'd0);

      // Carry and stickiness across LOAD
      run(mk(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0), 16'hFFFF, "load_ffff");
      run(mk(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'h0001, "load_one");
      run(mk(2'b10, 2'b00, 3'd5, 3'd1, 3'd2, 3'd0), 16'h0000, "alu_carry");
      check("alu_carry/r5", {16'd0, regs[5]}, 32'h0000);
      check("alu_carry/carry1", {31'd0, carry}, 32'd1);
      run(mk(2'b01, 2'b00, 3'd6, 3'd0, 3'd0, 3'd0), 16'h00AA, "load_keeps_carry");
      check("load_keeps_carry/carry1", {31'd0, carry}, 32'd1);

      // REP n=3 accumulate
      run(mk(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0), 16'h0005, "rep_r1");
      run(mk(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'h0003, "rep_r2");
      run(mk(2'b11, 2'b00, 3'd1, 3'd1, 3'd2, 3'd3), 16'h0000, "rep_add");
      check("rep_add/r1", {16'd0, regs[1]}, 32'd17);

      // NOP
      run(mk(2'b00, 2'b00, 3'd3, 3'd0, 3'd0, 3'd0), 16'h0000, "nop");

      // Handshake: held valid during busy is not consumed early
      ins = mk(2'b10, 2'b00, 3'd7, 3'd1, 3'd2, 3'd0);
      wait_ready("hs");
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr = mk(2'b01, 2'b00, 3'd7, 3'd0, 3'd0, 3'd0);
      imm_in = 16'hBEEF;
      check("hs/ready_exec", {31'd0, instr_ready}, 32'd0);
      check("hs/busy_exec", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      check("hs/ready_wb", {31'd0, instr_ready}, 32'd0);
      check("hs/wr_wb", {31'd0, wr}, 32'd1);
      @(posedge clk);
      #1;
      model_iter(ins, 1);
      check("hs/ready_idle", {31'd0, instr_ready}, 32'd1);
      check("hs/r7_alu", {16'd0, regs[7]}, {16'd0, mregs[7]});
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      check("hs/load_wr", {31'd0, wr}, 32'd1);
      check("hs/load_s", {31'd0, s}, 32'd1);
      @(posedge clk);
      #1;
      mregs[7] = 16'hBEEF;
      check("hs/r7_load", {16'd0, regs[7]}, 32'hBEEF);

      // Reset mid-REP during the third write-back
      run(mk(2'b01, 2'b00, 3'd1, 3'd0, 3'd0, 3'd0), 16'hFFFF, "mrst_r1");
      run(mk(2'b01, 2'b00, 3'd2, 3'd0, 3'd0, 3'd0), 16'hFFFF, "mrst_r2");
      ins = mk(2'b11, 2'b00, 3'd1, 3'd1, 3'd2, 3'd7);
      wait_ready("mrst");
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      model_iter(ins, 2);
      check("mrst/wr_before", {31'd0, wr}, 32'd1);
      check("mrst/carry_before", {31'd0, carry}, {31'd0, mcarry});
      #2;
      reset = 1'b0;
      #1;
      mcarry = 1'b0;
      check("mrst/wr_async", {31'd0, wr}, 32'd0);
      check("mrst/busy", {31'd0, busy}, 32'd0);
      check("mrst/carry", {31'd0, carry}, 32'd0);
      check("mrst/ready", {31'd0, instr_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("mrst/write_suppressed", {16'd0, regs[1]}, {16'd0, mregs[1]});
      @(negedge clk);
      reset = 1'b1;
      check("mrst/busy_after", {31'd0, busy}, 32'd0);

      // Randomized instruction stream
      for (int i = 0; i < 25; i++) begin
         run(16'($urandom), 16'($urandom), $sformatf("rand%0d", i));
      end
      for (int r = 0; r < 8; r++) begin
         check($sformatf("final_r%0d", r), {16'd0, regs[r]}, {16'd0, mregs[r]});
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
